exec_alu_unit: RTL and testbench
================================

Name: exec_alu_unit

Overview:
Execute-stage arithmetic block of the 5-stage MIPS pipeline. It combines three functions:
- ALU control decode from ALUop and funct.
- 32-bit ALU producing a result and a zero flag.
- 32-bit branch-target adder (PC+4 plus word-shifted offset).

All outputs are registered on the rising clock edge, so results are available to the EX/MEM boundary one cycle after inputs are presented.

Parameters:
WIDTH, 32, datapath width of ALU operands, result and adder (only 32 is required to be supported)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all registered outputs
alu_op  input  3  ALUop from main control
funct  input  6  instruction bits [5:0] (low bits of the sign-extended offset)
operand_a  input  32  ALU input 1 (rs data)
operand_b  input  32  ALU input 2 (rt data or sign-extended immediate, muxed upstream)
pc_plus4  input  32  incremented PC
imm_ext  input  32  sign-extended 16-bit offset
alu_ctrl  output  3  registered decoded ALU operation
alu_result  output  32  registered ALU result
zero  output  1  registered, 1 when the computed result is 0
overflow  output  1  registered signed overflow for add/sub, else 0
branch_target  output  32  registered pc_plus4 + (imm_ext << 2)

Behaviour:
- One clock, synchronous active-high reset.
- On a posedge with reset=1, the outputs are:
  - alu_ctrl=3'b010
  - alu_result=0
  - zero=1
  - overflow=0
  - branch_target=0
- Otherwise every output updates on each posedge from the current inputs. Latency is 1 cycle and there is no handshake.
- Control decode is combinational and internal; its value is also registered to alu_ctrl.
- ALUop decode:
  - 000 -> add (lw/sw/addi)
  - 001 -> sub (beq)
  - 010 -> R-type, decode from funct
  - 011 -> and
  - 100 -> or
  - 101 -> slt
  - 110, 111 -> add
- funct decode (ALUop=010):
  - 100000 -> add 010
  - 100010 -> sub 110
  - 100100 -> and 000
  - 100101 -> or 001
  - 100111 -> nor 100
  - 101010 -> slt 111
  - any other funct -> add 010
- ALU ops by ctrl code:
  - 000: a&b
  - 001: a|b
  - 010: a+b mod 2^32
  - 110: a-b mod 2^32
  - 100: ~(a|b)
  - 111: signed compare a<b -> 32'd1, else 32'd0
  - 011, 101: result 0
- zero: 1 iff the 32-bit result equals 0. This is computed from the same-cycle result, not the previously registered one.
- overflow:
  - add: operands have the same sign and the result sign differs.
  - sub: operands have different signs and the result sign differs from a.
  - All other ops: 0.
  - Overflow never alters the result (wrap-around).
- branch_target = pc_plus4 + {imm_ext[29:0],2'b00}, modulo 2^32.
  - Carry out is discarded.
  - A negative offset wraps correctly in two's complement.
- X/undefined inputs require no special handling. Reset is the only initialization mechanism.
- Reset asserted mid-stream overrides the inputs for that edge. The next non-reset edge produces normal results from the then-current inputs.

Test Plan:
- Reset=1 for one edge, arbitrary inputs -> alu_result=0, zero=1, overflow=0, branch_target=0, alu_ctrl=010.
- alu_op=010, funct=100000, a=9, b=11 -> next edge: alu_ctrl=010, alu_result=20, zero=0; then funct=100010, a=b=7 -> alu_result=0, zero=1, alu_ctrl=110.
- alu_op=010, a=32'hFFFF_FFFE (-2), b=1:
  - funct=101010 -> alu_result=1.
  - With a=5, b=32'hFFFF_FFFF -> alu_result=0 (signed compare).
- alu_op=010, funct=100100/100101/100111, a=32'hF0F0_00FF, b=32'h0FF0_0F0F -> results in order: 0x00F0_000F, 0xFFF0_0FFF, 0x000F_F000; funct=111111 -> treated as add.
- alu_op=000, a=32'h7FFF_FFFF, b=1 -> alu_result=32'h8000_0000, overflow=1.
- alu_op=001, a=32'h8000_0000, b=1 -> alu_result=32'h7FFF_FFFF, overflow=1.
- pc_plus4=32'd44, imm_ext=32'd3 -> branch_target=56.
- pc_plus4=32'd44, imm_ext=32'hFFFF_FFFD (-3) -> branch_target=32.
- pc_plus4=32'hFFFF_FFFC, imm_ext=1 -> branch_target=0 (wrap).

Source files
------------

// File: rtl/exec_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_unit
// Purpose  : EX-stage ALU control decode, 32-bit ALU and branch-target adder,
//            all results registered for the EX/MEM boundary.
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [WIDTH-1:0] imm_ext,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] branch_target
);

    localparam logic [2:0] C_CTRL_AND = 3'b000;
    localparam logic [2:0] C_CTRL_OR  = 3'b001;
    localparam logic [2:0] C_CTRL_ADD = 3'b010;
    localparam logic [2:0] C_CTRL_NOR = 3'b100;
    localparam logic [2:0] C_CTRL_SUB = 3'b110;
    localparam logic [2:0] C_CTRL_SLT = 3'b111;

    logic [2:0]       w_ctrl;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_overflow;
    logic [WIDTH-1:0] w_target;

    logic [2:0]       r_ctrl;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_overflow;
    logic [WIDTH-1:0] r_target;

    always_comb begin
        w_ctrl = C_CTRL_ADD;
        case (alu_op)
            3'b000:  w_ctrl = C_CTRL_ADD;
            3'b001:  w_ctrl = C_CTRL_SUB;
            3'b010: begin
                case (funct)
                    6'b100000: w_ctrl = C_CTRL_ADD;
                    6'b100010: w_ctrl = C_CTRL_SUB;
                    6'b100100: w_ctrl = C_CTRL_AND;
                    6'b100101: w_ctrl = C_CTRL_OR;
                    6'b100111: w_ctrl = C_CTRL_NOR;
                    6'b101010: w_ctrl = C_CTRL_SLT;
                    default:   w_ctrl = C_CTRL_ADD;
                endcase
            end
            3'b011:  w_ctrl = C_CTRL_AND;
            3'b100:  w_ctrl = C_CTRL_OR;
            3'b101:  w_ctrl = C_CTRL_SLT;
            default: w_ctrl = C_CTRL_ADD;
        endcase
    end

    assign w_sum  = operand_a + operand_b;
    assign w_diff = operand_a - operand_b;

    // Overflow is flagged only for add/sub; the result itself always wraps.
    always_comb begin
        w_result   = '0;
        w_overflow = 1'b0;
        case (w_ctrl)
            C_CTRL_AND: w_result = operand_a & operand_b;
            C_CTRL_OR:  w_result = operand_a | operand_b;
            C_CTRL_NOR: w_result = ~(operand_a | operand_b);
            C_CTRL_ADD: begin
                w_result   = w_sum;
                w_overflow = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            C_CTRL_SUB: begin
                w_result   = w_diff;
                w_overflow = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            C_CTRL_SLT: w_result = {{(WIDTH-1){1'b0}},
                                    ($signed(operand_a) < $signed(operand_b))};
            default:    w_result = '0;
        endcase
    end

    assign w_target = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= C_CTRL_ADD;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_overflow <= 1'b0;
            r_target   <= '0;
        end else begin
            r_ctrl     <= w_ctrl;
            r_result   <= w_result;
            r_zero     <= (w_result == '0);
            r_overflow <= w_overflow;
            r_target   <= w_target;
        end
    end

    assign alu_ctrl      = r_ctrl;
    assign alu_result    = r_result;
    assign zero          = r_zero;
    assign overflow      = r_overflow;
    assign branch_target = r_target;

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_alu_unit
// Purpose  : Scoreboard bench for exec_alu_unit using directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_alu_unit;

    typedef struct {
        string       name;
        logic [2:0]  ctrl;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] target;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] pc_plus4 = '0;
    logic [31:0] imm_ext = '0;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic [31:0] branch_target;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    exec_alu_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_op        (alu_op),
        .funct         (funct),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .pc_plus4      (pc_plus4),
        .imm_ext       (imm_ext),
        .alu_ctrl      (alu_ctrl),
        .alu_result    (alu_result),
        .zero          (zero),
        .overflow      (overflow),
        .branch_target (branch_target)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the matching expectation is queued
    // at the same moment and retired just after the next rising edge.
    task automatic drive(input string name, input logic rst, input logic [2:0] op,
                         input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [2:0] e_ctrl, input logic [31:0] e_res,
                         input logic e_zero, input logic e_ovf, input logic [31:0] e_tgt);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        alu_op    = op;
        funct     = fn;
        operand_a = a;
        operand_b = b;
        pc_plus4  = pc;
        imm_ext   = imm;
        e.name   = name;
        e.ctrl   = e_ctrl;
        e.result = e_res;
        e.zero   = e_zero;
        e.ovf    = e_ovf;
        e.target = e_tgt;
        scoreboard.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checks++;
                if (alu_ctrl !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s alu_ctrl got %b exp %b", e.name, alu_ctrl, e.ctrl);
                end
                checks++;
                if (alu_result !== e.result) begin
                    errors++;
                    $display("FAIL %s alu_result got %h exp %h", e.name, alu_result, e.result);
                end
                checks++;
                if (zero !== e.zero) begin
                    errors++;
                    $display("FAIL %s zero got %b exp %b", e.name, zero, e.zero);
                end
                checks++;
                if (overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL %s overflow got %b exp %b", e.name, overflow, e.ovf);
                end
                checks++;
                if (branch_target !== e.target) begin
                    errors++;
                    $display("FAIL %s branch_target got %h exp %h", e.name, branch_target, e.target);
                end
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        //       name         rst op      funct      a             b             pc            imm           ctrl    result        z  o  target
        drive("reset",        1, 3'b011, 6'h3F, 32'd123,      32'd456,      32'd100,      32'd7,        3'b010, 32'd0,        1, 0, 32'd0);
        drive("r_add",        0, 3'b010, 6'h20, 32'd9,        32'd11,       32'd0,        32'd0,        3'b010, 32'd20,       0, 0, 32'd0);
        drive("r_sub_zero",   0, 3'b010, 6'h22, 32'd7,        32'd7,        32'd0,        32'd0,        3'b110, 32'd0,        1, 0, 32'd0);
        drive("r_slt_true",   0, 3'b010, 6'h2A, 32'hFFFFFFFE, 32'd1,        32'd0,        32'd0,        3'b111, 32'd1,        0, 0, 32'd0);
        drive("r_slt_false",  0, 3'b010, 6'h2A, 32'd5,        32'hFFFFFFFF, 32'd0,        32'd0,        3'b111, 32'd0,        1, 0, 32'd0);
        drive("r_and",        0, 3'b010, 6'h24, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,        32'd0,        3'b000, 32'h00F0000F, 0, 0, 32'd0);
        drive("r_or",         0, 3'b010, 6'h25, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,        32'd0,        3'b001, 32'hFFF00FFF, 0, 0, 32'd0);
        drive("r_nor",        0, 3'b010, 6'h27, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,        32'd0,        3'b100, 32'h000FF000, 0, 0, 32'd0);
        drive("r_unknown",    0, 3'b010, 6'h3F, 32'hF0F000FF, 32'h0FF00F0F, 32'd0,        32'd0,        3'b010, 32'h00E0100E, 0, 0, 32'd0);
        drive("add_ovf",      0, 3'b000, 6'h00, 32'h7FFFFFFF, 32'd1,        32'd0,        32'd0,        3'b010, 32'h80000000, 0, 1, 32'd0);
        drive("sub_ovf",      0, 3'b001, 6'h00, 32'h80000000, 32'd1,        32'd0,        32'd0,        3'b110, 32'h7FFFFFFF, 0, 1, 32'd0);
        drive("sub_no_ovf",   0, 3'b001, 6'h00, 32'd3,        32'd5,        32'd0,        32'd0,        3'b110, 32'hFFFFFFFE, 0, 0, 32'd0);
        drive("bt_pos",       0, 3'b000, 6'h03, 32'd0,        32'd0,        32'd44,       32'd3,        3'b010, 32'd0,        1, 0, 32'd56);
        drive("bt_neg",       0, 3'b000, 6'h3D, 32'd1,        32'd2,        32'd44,       32'hFFFFFFFD, 3'b010, 32'd3,        0, 0, 32'd32);
        drive("bt_wrap",      0, 3'b000, 6'h01, 32'd0,        32'd0,        32'hFFFFFFFC, 32'd1,        3'b010, 32'd0,        1, 0, 32'd0);
        drive("op_and",       0, 3'b011, 6'h20, 32'hFFFFFFFF, 32'h8000000A, 32'd0,        32'd0,        3'b000, 32'h8000000A, 0, 0, 32'd0);
        drive("op_or",        0, 3'b100, 6'h22, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd0,        32'd0,        3'b001, 32'h7FFFFFFF, 0, 0, 32'd0);
        drive("op_slt",       0, 3'b101, 6'h20, 32'hFFFFFFFF, 32'd0,        32'd0,        32'd0,        3'b111, 32'd1,        0, 0, 32'd0);
        drive("op_110_add",   0, 3'b110, 6'h22, 32'd3,        32'd4,        32'd0,        32'd0,        3'b010, 32'd7,        0, 0, 32'd0);
        drive("op_111_add",   0, 3'b111, 6'h24, 32'hFFFFFFFF, 32'd1,        32'd8,        32'd1,        3'b010, 32'd0,        1, 0, 32'd12);
        drive("mid_reset",    1, 3'b010, 6'h22, 32'd100,      32'd1,        32'd40,       32'd2,        3'b010, 32'd0,        1, 0, 32'd0);
        drive("post_reset",   0, 3'b010, 6'h22, 32'd100,      32'd1,        32'd40,       32'd2,        3'b110, 32'd99,       0, 0, 32'd48);

        wait_cycles = 0;
        while (scoreboard.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (scoreboard.size() > 0) begin
            errors++;
            $display("FAIL drain %0d expectations left, required 0", scoreboard.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
